sine_display_seq: RTL

// Sequencer between the sine-table ROM and the 7-segment display path. On each

---
 rtl/sine_disp_pkg.sv | 28 ++
 rtl/sine_display_seq_if.sv | 11 +
 rtl/bcd_serial_conv.sv | 62 ++++++
 rtl/sine_display_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/sine_disp_pkg.sv
// Shared types, defaults and elaboration helpers for the sine display sequencer.
package sine_disp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_CONV,
    S_LOAD
  } state_e;

  // 10 Hz sample rate from a 50 MHz clock.
  localparam int unsigned TickDivDefault = 5_000_000;

  // Number of decimal digits needed to show 2^data_w-1.
  function automatic int unsigned digits_needed(int unsigned data_w);
    longint unsigned v;
    int unsigned     n;
    v = (64'd1 << data_w) - 64'd1;
    n = 1;
    while (v >= 64'd10) begin
      v = v / 64'd10;
      n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/sine_display_seq_if.sv
// ROM read bus between the sequencer (master) and the sine-table ROM (slave).
interface sine_display_seq_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 10
);
  logic [ADDR_W-1:0] ROM_ADDR;
  logic [DATA_W-1:0] ROM_DATA;

  modport master (output ROM_ADDR, input ROM_DATA);
  modport slave  (input ROM_ADDR, output ROM_DATA);
endinterface

// File: rtl/bcd_serial_conv.sv
// Iterative shift-add-3 binary to BCD converter, one bit per clock.
// done_o marks the final iteration; bcd_o holds the result from the next cycle on.
module bcd_serial_conv #(
  parameter int unsigned DATA_W = 10,
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [DATA_W-1:0]   bin_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [4*DIGITS-1:0] bcd_o
);
  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned BcdW = 4 * DIGITS;

  logic [DATA_W-1:0] bin_q, bin_d;
  logic [BcdW-1:0]   acc_q, acc_d, adj;
  logic [CntW-1:0]   cnt_q, cnt_d;

  // Add 3 to every digit >= 5 so that the following doubling carries correctly.
  always_comb begin
    adj = acc_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (acc_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
    end
  end

  // Load on start, otherwise run one iteration per clock until the counter empties.
  always_comb begin
    bin_d = bin_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (start_i) begin
      bin_d = bin_i;
      acc_d = '0;
      cnt_d = CntW'(DATA_W);
    end else if (cnt_q != '0) begin
      acc_d = BcdW'({adj, bin_q[DATA_W-1]});
      bin_d = bin_q << 1;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Datapath and iteration counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bin_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);
  assign done_o = (cnt_q == CntW'(1));
  assign bcd_o  = acc_q;
endmodule

// File: rtl/sine_display_seq.sv
// Sequencer: sample tick -> ROM read -> serial BCD conversion -> display registers.
module sine_display_seq
  import sine_disp_pkg::*;
#(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned ROM_LAT  = 1,
  parameter int unsigned TICK_DIV = TickDivDefault
) (
  input  logic                      CLOCK_50,
  input  logic                      RESET_N,
  input  logic                      MODE,
  input  logic [ADDR_W-1:0]         ADDR_IN,
  input  logic [ADDR_W-1:0]         STEP,
  sine_display_seq_if.master        rom_if,
  output logic [4*DIGITS-1:0]       BCD,
  output logic [DATA_W-1:0]         SAMPLE,
  output logic                      BUSY,
  output logic                      DONE,
  output logic                      OVERRUN
);
  localparam int unsigned PreW = $clog2(TICK_DIV);
  localparam int unsigned LatW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  if (DIGITS < digits_needed(DATA_W)) begin : g_digits_chk
    $error("DIGITS too small for the largest DATA_W sample");
  end
  if (ROM_LAT < 1 || TICK_DIV < 2) begin : g_param_chk
    $error("ROM_LAT must be >= 1 and TICK_DIV >= 2");
  end

  state_e              state_q, state_d;
  logic [PreW-1:0]     pre_q, pre_d;
  logic                pending_q, pending_d, overrun_q, overrun_d;
  logic                mode_q, mode_d;
  logic [ADDR_W-1:0]   phase_q, phase_d, rom_addr_q, rom_addr_d;
  logic [LatW-1:0]     wait_q, wait_d;
  logic [DATA_W-1:0]   data_q, data_d, sample_q, sample_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d, conv_bcd;
  logic                tick, consume, conv_start, conv_busy, conv_done;

  // Prescaler and one-deep tick queue; a tick landing on a live pending flag is an overrun.
  always_comb begin
    tick      = (pre_q == PreW'(TICK_DIV - 1));
    pre_d     = tick ? '0 : pre_q + PreW'(1);
    consume   = (state_q == S_IDLE) && pending_q;
    pending_d = tick | (pending_q & ~consume);
    overrun_d = overrun_q | (tick & pending_q & ~consume);
  end

  // FSM next state and datapath loads.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    mode_d     = mode_q;
    rom_addr_d = rom_addr_q;
    wait_d     = wait_q;
    data_d     = data_q;
    bcd_d      = bcd_q;
    sample_d   = sample_q;
    conv_start = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (pending_q) begin
          // Sweep only advances if the previous start was also in sweep mode.
          mode_d  = MODE;
          phase_d = (MODE && mode_q) ? phase_q + STEP : ADDR_IN;
          state_d = S_ADDR;
        end
      end
      S_ADDR: begin
        rom_addr_d = phase_q;
        wait_d     = LatW'(ROM_LAT - 1);
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          conv_start = 1'b1;
          data_d     = rom_if.ROM_DATA;
          state_d    = S_CONV;
        end else begin
          wait_d = wait_q - LatW'(1);
        end
      end
      S_CONV: begin
        if (conv_done || !conv_busy) state_d = S_LOAD;
      end
      S_LOAD: begin
        bcd_d    = conv_bcd;
        sample_d = data_q;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // All sequencer state; reset aborts any run in flight and drops the pending tick.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      pending_q  <= 1'b0;
      overrun_q  <= 1'b0;
      mode_q     <= 1'b0;
      phase_q    <= '0;
      rom_addr_q <= '0;
      wait_q     <= '0;
      data_q     <= '0;
      bcd_q      <= '0;
      sample_q   <= '0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      rom_addr_q <= rom_addr_d;
      wait_q     <= wait_d;
      data_q     <= data_d;
      bcd_q      <= bcd_d;
      sample_q   <= sample_d;
    end
  end

  bcd_serial_conv #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk_i   (CLOCK_50),
    .rst_ni  (RESET_N),
    .start_i (conv_start),
    .bin_i   (rom_if.ROM_DATA),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  assign rom_if.ROM_ADDR = rom_addr_q;
  assign BCD             = bcd_q;
  assign SAMPLE          = sample_q;
  assign BUSY            = (state_q != S_IDLE);
  assign DONE            = (state_q == S_LOAD);
  assign OVERRUN         = overrun_q;
endmodule
